// File: rtl/cla_zvn_compare.sv
// Carry-lookahead add/subtract unit with registered Z/V/N flags and signed compare decode.
// Optional sticky-overflow output is enabled by defining CLA_ZVN_STICKY_V_EN.
module cla_zvn_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alufn,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             cmp
`ifdef CLA_ZVN_STICKY_V_EN
    ,
    output logic             v_sticky
`endif
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int NW = NG * 4;

    // Group generate: carry produced inside a 4-bit group regardless of its carry-in.
    function automatic logic grp_gen(input logic [3:0] g, input logic [3:1] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carries into bits 1..3 of a group, fully expanded from the group carry-in.
    function automatic logic [2:0] grp_inner_carry(input logic [2:0] g, input logic [2:0] p,
                                                   input logic cin);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    logic [WIDTH-1:0] bx_s;
    logic [NW-1:0]    a_ext_s;
    logic [NW-1:0]    bx_ext_s;
    logic [NW-1:0]    g_s;
    logic [NW-1:0]    p_s;
    logic [NW-1:0]    sum_ext_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG-1:0]    grp_p_s;
    logic [NG:0]      grp_c_s;
    logic [NW:0]      c_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             z_s;
    logic             v_s;
    logic             n_s;
    logic             cmp_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             z_r;
    logic             v_r;
    logic             n_r;
    logic             cmp_r;

    assign bx_s = b ^ {WIDTH{alufn[0]}};

    // Zero-extend operands to a whole number of lookahead groups.
    always_comb begin
        a_ext_s              = {NW{1'b0}};
        bx_ext_s             = {NW{1'b0}};
        a_ext_s[WIDTH-1:0]   = a;
        bx_ext_s[WIDTH-1:0]  = bx_s;
    end

    assign g_s = a_ext_s & bx_ext_s;
    assign p_s = a_ext_s ^ bx_ext_s;

    genvar k;
    generate
        for (k = 0; k < NG; k++) begin : g_grp
            assign grp_g_s[k]            = grp_gen(g_s[4*k +: 4], p_s[4*k+1 +: 3]);
            assign grp_p_s[k]            = &p_s[4*k +: 4];
            assign c_s[4*k]              = grp_c_s[k];
            assign c_s[4*k+3 : 4*k+1]    = grp_inner_carry(g_s[4*k +: 3], p_s[4*k +: 3],
                                                           grp_c_s[k]);
        end
    endgenerate
    assign c_s[NW] = grp_c_s[NG];

    // Second-level lookahead: each group carry-in expanded from group G/P and the adder carry-in.
    always_comb begin
        logic term_v;
        logic pp_v;
        grp_c_s    = {(NG+1){1'b0}};
        grp_c_s[0] = alufn[0];
        for (int gi = 1; gi <= NG; gi++) begin
            term_v = 1'b0;
            for (int j = 0; j < gi; j++) begin
                pp_v = 1'b1;
                for (int m = j + 1; m < gi; m++) begin
                    pp_v = pp_v & grp_p_s[m];
                end
                term_v = term_v | (grp_g_s[j] & pp_v);
            end
            pp_v = 1'b1;
            for (int m = 0; m < gi; m++) begin
                pp_v = pp_v & grp_p_s[m];
            end
            grp_c_s[gi] = term_v | (pp_v & alufn[0]);
        end
    end

    assign sum_ext_s = p_s ^ c_s[NW-1:0];
    assign sum_s     = sum_ext_s[WIDTH-1:0];
    assign cout_s    = c_s[WIDTH];

    assign z_s = (sum_s == {WIDTH{1'b0}});
    assign n_s = sum_s[WIDTH-1];
    assign v_s = (a[WIDTH-1] & bx_s[WIDTH-1] & ~sum_s[WIDTH-1]) |
                 (~a[WIDTH-1] & ~bx_s[WIDTH-1] & sum_s[WIDTH-1]);

    // Compare decode; signed less-than is N xor V.
    always_comb begin
        cmp_s = 1'b0;
        case (alufn[2:1])
            2'b00:   cmp_s = 1'b0;
            2'b01:   cmp_s = z_s;
            2'b10:   cmp_s = n_s ^ v_s;
            2'b11:   cmp_s = z_s | (n_s ^ v_s);
            default: cmp_s = 1'b0;
        endcase
    end

    // Result register: loads on valid input, otherwise holds results and drops out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            z_r         <= 1'b0;
            v_r         <= 1'b0;
            n_r         <= 1'b0;
            cmp_r       <= 1'b0;
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            sum_r       <= sum_s;
            cout_r      <= cout_s;
            z_r         <= z_s;
            v_r         <= v_s;
            n_r         <= n_s;
            cmp_r       <= cmp_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef CLA_ZVN_STICKY_V_EN
    logic v_sticky_r;

    // Sticky overflow: set by any valid overflowing result, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sticky_r <= 1'b0;
        end else if (in_valid && v_s) begin
            v_sticky_r <= 1'b1;
        end else begin
            v_sticky_r <= v_sticky_r;
        end
    end

    assign v_sticky = v_sticky_r;
`endif

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign z         = z_r;
    assign v         = v_r;
    assign n         = n_r;
    assign cmp       = cmp_r;

endmodule

// File: tb/tb_cla_zvn_compare.sv
// Table-driven bench for cla_zvn_compare at WIDTH=3, plus hold and reset sequences.
module tb_cla_zvn_compare;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alufn;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         z;
    logic         v;
    logic         n;
    logic         cmp;
`ifdef CLA_ZVN_STICKY_V_EN
    logic         v_sticky;
`endif

    int pass_cnt;
    int total_cnt;
    logic sticky_exp;

    cla_zvn_compare #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alufn     (alufn),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .z         (z),
        .v         (v),
        .n         (n),
        .cmp       (cmp)
`ifdef CLA_ZVN_STICKY_V_EN
        ,
        .v_sticky  (v_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   alufn;
        logic [W-1:0] sum;
        logic         cout;
        logic         z;
        logic         v;
        logic         n;
        logic         cmp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input vec_t e);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".sum"},  {29'd0, sum},  {29'd0, e.sum});
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, e.cout});
        chk({tag, ".z"},    {31'd0, z},    {31'd0, e.z});
        chk({tag, ".v"},    {31'd0, v},    {31'd0, e.v});
        chk({tag, ".n"},    {31'd0, n},    {31'd0, e.n});
        chk({tag, ".cmp"},  {31'd0, cmp},  {31'd0, e.cmp});
`ifdef CLA_ZVN_STICKY_V_EN
        chk({tag, ".v_sticky"}, {31'd0, v_sticky}, {31'd0, sticky_exp});
`endif
    endtask

    task automatic drive(input vec_t e);
        a        = e.a;
        b        = e.b;
        alufn    = e.alufn;
        in_valid = 1'b1;
    endtask

    vec_t zero_v;
    vec_t last_v;

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        sticky_exp = 1'b0;
        zero_v     = '{3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        //            a     b     alufn     sum  cout  z     v     n     cmp
        vecs[0]  = '{3'd1, 3'd2, 3'b011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd3, 3'd2, 3'b011, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 3'd2, 3'b111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd2, 3'd3, 3'b101, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'd7, 3'd1, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'd4, 3'd1, 3'b101, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{3'd5, 3'd3, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 3'd3, 3'b011, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'd3, 3'd3, 3'b111, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'd3, 3'd1, 3'b000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'd3, 3'd1, 3'b100, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'd2, 3'd2, 3'b010, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{3'd4, 3'd4, 3'b110, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'd0, 3'd0, 3'b101, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 3'd0;
        b        = 3'd0;
        alufn    = 3'd0;
        #1;
        chk_all("reset", 1'b0, zero_v);

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors, one result per cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            sticky_exp = sticky_exp | vecs[i].v;
            #1;
            chk_all($sformatf("vec%0d", i), 1'b1, vecs[i]);
        end
        last_v = vecs[13];

        // Idle cycle: results hold, out_valid drops.
        @(negedge clk);
        in_valid = 1'b0;
        a        = 3'd5;
        b        = 3'd6;
        alufn    = 3'b111;
        @(posedge clk);
        #1;
        chk_all("hold", 1'b0, last_v);

        // Add with carry-out then asynchronous reset between edges.
        @(negedge clk);
        drive(vecs[6]);
        @(posedge clk);
        #1;
        chk_all("add_pre_rst", 1'b1, vecs[6]);
        #2;
        rst_n = 1'b0;
        #1;
        sticky_exp = 1'b0;
        chk_all("async_rst", 1'b0, zero_v);

        // In-flight input discarded by reset asserted before the edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[0]);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all("inflight_discard", 1'b0, zero_v);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst_idle", 1'b0, zero_v);

        @(negedge clk);
        drive(vecs[5]);
        @(posedge clk);
        sticky_exp = 1'b1;
        #1;
        chk_all("first_after_rst", 1'b1, vecs[5]);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("hold_after_rst", 1'b0, vecs[5]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
